// File: rtl/banco_registradores_param_if.sv
// Bus bundle for banco_registradores_param: two write ports, two read ports.
// master drives writes and read addresses; slave is the register bank.
interface banco_registradores_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] dado_escrita;
  logic              RegWrite2;
  logic [ADDR_W-1:0] rd2;
  logic [DATA_W-1:0] dado_escrita2;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] dado1;
  logic [DATA_W-1:0] dado2;
  logic              valido1;
  logic              valido2;

  modport master (
    output RegWrite, rd, dado_escrita,
    output RegWrite2, rd2, dado_escrita2,
    output rs, rt,
    input  dado1, dado2, valido1, valido2
  );

  modport slave (
    input  RegWrite, rd, dado_escrita,
    input  RegWrite2, rd2, dado_escrita2,
    input  rs, rt,
    output dado1, dado2, valido1, valido2
  );
endinterface

// File: rtl/banco_registradores_param.sv
// Dual-write, dual-read register bank with per-register valid bits.
// Optional BANCO_BYPASS_EN forwards same-edge writes to the read ports.
module banco_registradores_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic clock,
  input logic reset_n,
  banco_registradores_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic w1_en;
  logic w2_en;

  // Port 1 wins a same-address collision, so port 2 drops out.
  assign w1_en = bus.RegWrite
               && !(ZR && bus.rd == '0);
  assign w2_en = bus.RegWrite2
               && !(ZR && bus.rd2 == '0)
               && !(w1_en && bus.rd2 == bus.rd);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld <= '0;
    end else begin
      if (w2_en) begin
        mem[bus.rd2] <= bus.dado_escrita2;
        vld[bus.rd2] <= 1'b1;
      end
      if (w1_en) begin
        mem[bus.rd] <= bus.dado_escrita;
        vld[bus.rd] <= 1'b1;
      end
    end
  end

  logic [ADDR_W-1:0] ra   [2];
  logic [DATA_W-1:0] rdat [2];
  logic              rv   [2];

  assign ra[0] = bus.rs;
  assign ra[1] = bus.rt;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = mem[ra[p]];
      rv[p]   = vld[ra[p]];
      if (ZR && ra[p] == '0) begin
        rdat[p] = '0;
        rv[p]   = 1'b1;
      end
`ifdef BANCO_BYPASS_EN
      else if (w1_en && ra[p] == bus.rd) begin
        rdat[p] = bus.dado_escrita;
        rv[p]   = 1'b1;
      end else if (w2_en && ra[p] == bus.rd2) begin
        rdat[p] = bus.dado_escrita2;
        rv[p]   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.dado1   <= '0;
      bus.dado2   <= '0;
      bus.valido1 <= 1'b0;
      bus.valido2 <= 1'b0;
    end else begin
      bus.dado1   <= rdat[0];
      bus.dado2   <= rdat[1];
      bus.valido1 <= rv[0];
      bus.valido2 <= rv[1];
    end
  end

endmodule
